fpa_result_queue: RTL and testbench
===================================

// Module: fpa_result_queue
// PURPOSE
//  Downstream stage of the FP add/sub pipeline. Captures each Result word qualified by the
//  pipeline's Value_Out pulse and classifies it (zero/denormal/inf/NaN). Buffers results in a
//  DEPTH-entry FIFO and presents them to the consumer with a valid/ready handshake.
//  Issues credit-based back-pressure (Issue_Ok) to the operand issuer, because the FP pipeline
//  itself cannot stall.
// PARAMETERS
//  DEPTH     8   FIFO entries; power of two, >= 2
//  PIPE_LAT  4   max results in flight inside the FP pipeline (documentation/assert only)
// PORTS
//  Clk         in   1      single clock, rising edge
//  Clear       in   1      reset, asynchronous, active-low
//  Issue       in   1      issuer launched an op into the FP pipeline this cycle (its Value_In)
//  Issue_Ok    out  1      1 = a new Issue is permitted this cycle
//  Value_In    in   1      FP pipeline Value_Out: Result_In valid this cycle
//  Result_In   in   32     FP pipeline Result, IEEE-754 single
//  Out_Valid   out  1      head entry valid
//  Out_Ready   in   1      consumer accepts head when Out_Valid & Out_Ready
//  Out_Data    out  32     head result
//  Out_Class   out  4      {NaN,Inf,Denorm,Zero} of head; 4'b0000 = normal
//  Count       out  $clog2(DEPTH)+1  stored entries
//  Overflow_Err out 1      sticky: result dropped or Issue made while Issue_Ok=0
// BEHAVIOUR
//  Reset (Clear=0, async): pointers, Count, Inflight, Overflow_Err, flags -> 0. Out_Valid=0,
//   Issue_Ok=1, Out_Data/Out_Class = 0 (storage contents don't care). Mid-op reset drops all.
//  Classify at push from Result_In[30:23] (exp), [22:0] (mant): exp=0,mant=0 Zero;
//   exp=0,mant!=0 Denorm; exp=FF,mant=0 Inf; exp=FF,mant!=0 NaN; else normal. Sign ignored.
//   Class bits stored alongside data (36-bit entry).
//  push = Value_In & (Count<DEPTH | pop); pop = Out_Valid & Out_Ready.
//  Latency: a result pushed at edge N is on Out_Data with Out_Valid=1 after edge N (no bypass).
//  Out_Valid = (Count!=0); Out_Data/Out_Class driven from storage[rd_ptr], stable while stalled.
//  Simultaneous push+pop: Count unchanged; allowed when full (slot freed same edge).
//  Value_In while full and no pop: result dropped, Overflow_Err<=1, Count unchanged.
//  Pointers are log2(DEPTH) bits, wrap naturally DEPTH-1 -> 0.
//  Inflight counter ($clog2(DEPTH)+1 bits): +1 on Issue, -1 on Value_In, both = unchanged.
//   Value_In with Inflight=0: Inflight stays 0 (saturate), result still pushed normally.
//  Issue_Ok = (Count + Inflight) < DEPTH, combinational from registered state.
//  Issue while Issue_Ok=0: still counted in Inflight (saturates at DEPTH), Overflow_Err<=1.
//  Overflow_Err cleared only by reset.
// CONFIGURATION
//  FPA_STICKY_FLAGS_EN defined: adds ports Flag_Clr (in,1) and Flags (out,4). Flags ORs the
//   class bits of every pushed entry {NaN,Inf,Denorm,Zero}; Flag_Clr=1 clears to 0 at next
//   edge; a push coinciding with Flag_Clr loads that entry's class bits (clear then set).
//   Reset -> 0.
//  Undefined: ports absent, no flag logic; all other behaviour identical.
// TESTING
//  T1 reset: Clear=0 mid-stream -> Out_Valid=0, Count=0, Issue_Ok=1, Overflow_Err=0 at once.
//  T2 single: Issue; 4 cycles later Value_In with 32'h42728A3D -> next cycle Out_Valid=1,
//   Out_Data=32'h42728A3D, Out_Class=0; Out_Ready=1 -> Count 1->0.
//  T3 classify: push 32'h00000000, 32'h00000001, 32'h7F800000, 32'h7FC00000 ->
//   Out_Class 0001, 0010, 0100, 1000 in order.
//  T4 credit: 8 Issues, Out_Ready=0 -> Issue_Ok=0 after 8th; 9th Issue -> Overflow_Err=1.
//  T5 full: 8 stored, Value_In with Out_Ready=1 -> accepted, Count stays 8; Out_Ready=0 ->
//   dropped, Overflow_Err=1, Count=8, head unchanged.
//  T6 wrap: 20 push/pop pairs at full rate -> data order preserved across pointer wrap.
//  T7 (FPA_STICKY_FLAGS_EN): push Inf, then NaN -> Flags=1100; Flag_Clr with Zero push -> 0001.

Source files
------------

// File: rtl/fpa_result_queue_if.sv
// Handshake/bus bundle between the FP pipeline, the result queue and its consumer.
// FPA_STICKY_FLAGS_EN adds Flag_Clr/Flags to the bundle.
interface fpa_result_queue_if #(
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          Issue;
   logic          Issue_Ok;
   logic          Value_In;
   logic [31:0]   Result_In;
   logic          Out_Valid;
   logic          Out_Ready;
   logic [31:0]   Out_Data;
   logic [3:0]    Out_Class;
   logic [CW-1:0] Count;
   logic          Overflow_Err;
`ifdef FPA_STICKY_FLAGS_EN
   logic          Flag_Clr;
   logic [3:0]    Flags;

   modport master (
      output Issue, Value_In, Result_In, Out_Ready, Flag_Clr,
      input  Issue_Ok, Out_Valid, Out_Data, Out_Class, Count, Overflow_Err, Flags
   );
   modport slave (
      input  Issue, Value_In, Result_In, Out_Ready, Flag_Clr,
      output Issue_Ok, Out_Valid, Out_Data, Out_Class, Count, Overflow_Err, Flags
   );
`else
   modport master (
      output Issue, Value_In, Result_In, Out_Ready,
      input  Issue_Ok, Out_Valid, Out_Data, Out_Class, Count, Overflow_Err
   );
   modport slave (
      input  Issue, Value_In, Result_In, Out_Ready,
      output Issue_Ok, Out_Valid, Out_Data, Out_Class, Count, Overflow_Err
   );
`endif
endinterface

// File: rtl/fpa_result_queue.sv
// Result FIFO behind the FP add/sub pipeline: classifies results, credit-based Issue_Ok.
// Optional sticky class flags when FPA_STICKY_FLAGS_EN is defined.
module fpa_result_queue #(
   parameter int DEPTH    = 8,
   parameter int PIPE_LAT = 4
) (
   input logic                 Clk,
   input logic                 Clear,
   fpa_result_queue_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // Handshake: the head is consumed on a rising edge where Out_Valid & Out_Ready;
   // Out_Valid never depends on Out_Ready.
   logic [35:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] r_inflight;
   logic          r_ovf;

   logic [7:0]    w_exp;
   logic [22:0]   w_mant;
   logic [3:0]    w_class;
   logic          w_full;
   logic          w_push;
   logic          w_pop;
   logic          w_out_valid;
   logic [CW:0]   w_credit_sum;
   logic          w_issue_ok;

   assign w_exp   = bus.Result_In[30:23];
   assign w_mant  = bus.Result_In[22:0];
   assign w_class = {(w_exp == 8'hFF) && (w_mant != '0),
                     (w_exp == 8'hFF) && (w_mant == '0),
                     (w_exp == 8'h00) && (w_mant != '0),
                     (w_exp == 8'h00) && (w_mant == '0)};

   assign w_out_valid  = (r_count != '0);
   assign w_full       = (r_count == CW'(DEPTH));
   assign w_pop        = w_out_valid & bus.Out_Ready;
   assign w_push       = bus.Value_In & (~w_full | w_pop);
   assign w_credit_sum = {1'b0, r_count} + {1'b0, r_inflight};
   assign w_issue_ok   = (w_credit_sum < (CW+1)'(DEPTH));

   // Storage needs no reset; outputs are gated by Out_Valid instead.
   always_ff @(posedge Clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {w_class, bus.Result_In};
   end

   always_ff @(posedge Clk or negedge Clear) begin
      if (!Clear) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_inflight <= '0;
         r_ovf      <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);

         if (w_push && !w_pop)      r_count <= r_count + CW'(1);
         else if (!w_push && w_pop) r_count <= r_count - CW'(1);

         // Saturate at DEPTH on excess issues and at 0 on unexpected results.
         if (bus.Issue && !bus.Value_In && (r_inflight < CW'(DEPTH)))
            r_inflight <= r_inflight + CW'(1);
         else if (!bus.Issue && bus.Value_In && (r_inflight != '0))
            r_inflight <= r_inflight - CW'(1);

         if ((bus.Value_In && !w_push) || (bus.Issue && !w_issue_ok))
            r_ovf <= 1'b1;
      end
   end

`ifdef FPA_STICKY_FLAGS_EN
   logic [3:0] r_flags;

   // Clear has priority over history but not over the entry pushed on the same edge.
   always_ff @(posedge Clk or negedge Clear) begin
      if (!Clear)
         r_flags <= '0;
      else
         r_flags <= (bus.Flag_Clr ? 4'b0000 : r_flags) | (w_push ? w_class : 4'b0000);
   end

   assign bus.Flags = r_flags;
`endif

   assign bus.Out_Valid    = w_out_valid;
   assign bus.Out_Data     = w_out_valid ? r_mem[r_rd_ptr][31:0]  : 32'h0;
   assign bus.Out_Class    = w_out_valid ? r_mem[r_rd_ptr][35:32] : 4'h0;
   assign bus.Count        = r_count;
   assign bus.Issue_Ok     = w_issue_ok;
   assign bus.Overflow_Err = r_ovf;

   a_bounds: assert property (@(posedge Clk) disable iff (!Clear)
      (r_count <= CW'(DEPTH)) && (r_inflight <= CW'(DEPTH)) && (PIPE_LAT <= DEPTH) && (DEPTH >= 2));
endmodule

// File: tb/tb_fpa_result_queue.sv
// Directed bench for fpa_result_queue: cycle table plus hand sequences with an expected queue.
// Exercises the flag path too when FPA_STICKY_FLAGS_EN is defined.
module tb_fpa_result_queue;
   localparam int DEPTH = 8;

   logic clk;
   logic clear;
   int   n_checks;
   int   n_fail;
   int   m_count;
   logic [31:0] exp_q [$];

   fpa_result_queue_if #(.DEPTH(DEPTH)) bus ();

   fpa_result_queue #(.DEPTH(DEPTH), .PIPE_LAT(4)) dut (
      .Clk   (clk),
      .Clear (clear),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        issue;
      logic        vin;
      logic [31:0] res;
      logic        rdy;
      logic        e_valid;
      logic [31:0] e_data;
      logic [3:0]  e_class;
      logic [3:0]  e_count;
      logic        e_ok;
   } vec_t;

   vec_t vecs [19];

   task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One clock of stimulus with scoreboard tracking of pushes and pops.
   task automatic drive_cycle(input logic iss, input logic vin, input logic [31:0] d,
                              input logic rdy);
      logic pop;
      logic push;
      logic [31:0] e;
      bus.Issue     = iss;
      bus.Value_In  = vin;
      bus.Result_In = d;
      bus.Out_Ready = rdy;
      pop = bus.Out_Valid && rdy;
      if (pop) begin
         if (exp_q.size() == 0) begin
            chk("valid_when_empty", 36'(bus.Out_Valid), 36'h0);
         end else begin
            e = exp_q.pop_front();
            chk("head_data", 36'(bus.Out_Data), 36'(e));
         end
      end
      push = vin && ((m_count < DEPTH) || pop);
      if (push) exp_q.push_back(d);
      m_count = m_count + int'(push) - int'(pop);
      step();
      chk("count", 36'(bus.Count), 36'(m_count));
      chk("out_valid", 36'(bus.Out_Valid), 36'(m_count != 0));
   endtask

   task automatic idle_inputs();
      bus.Issue     = 1'b0;
      bus.Value_In  = 1'b0;
      bus.Result_In = 32'h0;
      bus.Out_Ready = 1'b0;
`ifdef FPA_STICKY_FLAGS_EN
      bus.Flag_Clr  = 1'b0;
`endif
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_valid"}, 36'(bus.Out_Valid), 36'h0);
      chk({tag, "_count"}, 36'(bus.Count), 36'h0);
      chk({tag, "_issue_ok"}, 36'(bus.Issue_Ok), 36'h1);
      chk({tag, "_ovf"}, 36'(bus.Overflow_Err), 36'h0);
      chk({tag, "_data"}, 36'(bus.Out_Data), 36'h0);
      chk({tag, "_class"}, 36'(bus.Out_Class), 36'h0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      m_count  = 0;
      idle_inputs();
      clear = 1'b0;

      //            iss vin res           rdy  val data          cls    cnt   ok
      vecs[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        4'h0, 4'd0, 1'b1};
      vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        4'h0, 4'd0, 1'b1};
      vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        4'h0, 4'd0, 1'b1};
      vecs[3]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        4'h0, 4'd0, 1'b1};
      vecs[4]  = '{1'b0, 1'b1, 32'h42728A3D, 1'b0, 1'b1, 32'h42728A3D, 4'h0, 4'd1, 1'b1};
      vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        4'h0, 4'd0, 1'b1};
      vecs[6]  = '{1'b0, 1'b1, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 4'h1, 4'd1, 1'b1};
      vecs[7]  = '{1'b0, 1'b1, 32'h00000001, 1'b0, 1'b1, 32'h00000000, 4'h1, 4'd2, 1'b1};
      vecs[8]  = '{1'b0, 1'b1, 32'h7F800000, 1'b0, 1'b1, 32'h00000000, 4'h1, 4'd3, 1'b1};
      vecs[9]  = '{1'b0, 1'b1, 32'h7FC00000, 1'b0, 1'b1, 32'h00000000, 4'h1, 4'd4, 1'b1};
      vecs[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h00000001, 4'h2, 4'd3, 1'b1};
      vecs[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h7F800000, 4'h4, 4'd2, 1'b1};
      vecs[12] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h7FC00000, 4'h8, 4'd1, 1'b1};
      vecs[13] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        4'h0, 4'd0, 1'b1};
      vecs[14] = '{1'b0, 1'b1, 32'hFF800000, 1'b1, 1'b1, 32'hFF800000, 4'h4, 4'd1, 1'b1};
      vecs[15] = '{1'b0, 1'b1, 32'h80000001, 1'b1, 1'b1, 32'h80000001, 4'h2, 4'd1, 1'b1};
      vecs[16] = '{1'b0, 1'b1, 32'h3F800000, 1'b1, 1'b1, 32'h3F800000, 4'h0, 4'd1, 1'b1};
      vecs[17] = '{1'b0, 1'b1, 32'h7F7FFFFF, 1'b1, 1'b1, 32'h7F7FFFFF, 4'h0, 4'd1, 1'b1};
      vecs[18] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        4'h0, 4'd0, 1'b1};

      // Reset state while Clear is held low.
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("reset");
      clear = 1'b1;

      // Single result latency and classification table (T2, T3).
      for (int i = 0; i < 19; i++) begin
         bus.Issue     = vecs[i].issue;
         bus.Value_In  = vecs[i].vin;
         bus.Result_In = vecs[i].res;
         bus.Out_Ready = vecs[i].rdy;
         step();
         chk($sformatf("vec%0d_valid", i), 36'(bus.Out_Valid), 36'(vecs[i].e_valid));
         chk($sformatf("vec%0d_data", i), 36'(bus.Out_Data), 36'(vecs[i].e_data));
         chk($sformatf("vec%0d_class", i), 36'(bus.Out_Class), 36'(vecs[i].e_class));
         chk($sformatf("vec%0d_count", i), 36'(bus.Count), 36'(vecs[i].e_count));
         chk($sformatf("vec%0d_issue_ok", i), 36'(bus.Issue_Ok), 36'(vecs[i].e_ok));
         chk($sformatf("vec%0d_ovf", i), 36'(bus.Overflow_Err), 36'h0);
      end
      idle_inputs();

      // Full FIFO: push+pop accepted when full, plain push dropped (T5).
      for (int i = 0; i < DEPTH; i++) drive_cycle(1'b0, 1'b1, 32'h10000000 + 32'(i), 1'b0);
      chk("full_issue_ok", 36'(bus.Issue_Ok), 36'h0);
      chk("full_ovf", 36'(bus.Overflow_Err), 36'h0);
      chk("full_head", 36'(bus.Out_Data), 36'h10000000);
      drive_cycle(1'b0, 1'b1, 32'h20000000, 1'b1);
      chk("full_pushpop_ovf", 36'(bus.Overflow_Err), 36'h0);
      drive_cycle(1'b0, 1'b1, 32'h30000000, 1'b0);
      chk("drop_ovf", 36'(bus.Overflow_Err), 36'h1);
      chk("drop_head", 36'(bus.Out_Data), 36'h10000001);
      for (int i = 0; i < DEPTH; i++) drive_cycle(1'b0, 1'b0, 32'h0, 1'b1);
      chk("drain_ovf_sticky", 36'(bus.Overflow_Err), 36'h1);

      // Mid-stream asynchronous reset (T1).
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, 32'h50000000 + 32'(i), 1'b0);
      drive_cycle(1'b1, 1'b0, 32'h0, 1'b0);
      #2 clear = 1'b0;
      #1 check_reset_state("midreset");
      idle_inputs();
      #2 clear = 1'b1;
      exp_q.delete();
      m_count = 0;
      step();

      // Credits: 8 issues exhaust, 9th flags overflow, inflight saturates both ways (T4).
      for (int i = 0; i < DEPTH; i++) begin
         drive_cycle(1'b1, 1'b0, 32'h0, 1'b0);
         chk($sformatf("credit%0d_issue_ok", i), 36'(bus.Issue_Ok), 36'(i < DEPTH - 1));
      end
      chk("credit_ovf", 36'(bus.Overflow_Err), 36'h0);
      drive_cycle(1'b1, 1'b0, 32'h0, 1'b0);
      chk("extra_issue_ovf", 36'(bus.Overflow_Err), 36'h1);
      chk("extra_issue_ok", 36'(bus.Issue_Ok), 36'h0);
      for (int k = 1; k <= 9; k++) begin
         drive_cycle(1'b0, 1'b1, 32'hB0000000 + 32'(k), 1'b1);
         chk($sformatf("return%0d_issue_ok", k), 36'(bus.Issue_Ok), 36'(k >= 2));
      end
      drive_cycle(1'b0, 1'b0, 32'h0, 1'b1);

      // Pointer wrap at full rate with 5 entries resident (T6).
      for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b1, 32'hA0000000 + 32'(i), 1'b0);
      for (int i = 5; i < 25; i++) drive_cycle(1'b0, 1'b1, 32'hA0000000 + 32'(i), 1'b1);
      for (int i = 0; i < DEPTH; i++) drive_cycle(1'b0, 1'b0, 32'h0, 1'b1);
      chk("wrap_leftover", 36'(exp_q.size()), 36'h0);

`ifdef FPA_STICKY_FLAGS_EN
      // Sticky flags accumulate, clear-with-push loads the new class (T7).
      drive_cycle(1'b0, 1'b1, 32'h7F800000, 1'b1);
      chk("flags_inf", 36'(bus.Flags), 36'h4);
      drive_cycle(1'b0, 1'b1, 32'h7FC00000, 1'b1);
      chk("flags_inf_nan", 36'(bus.Flags), 36'hC);
      bus.Flag_Clr = 1'b1;
      drive_cycle(1'b0, 1'b1, 32'h00000000, 1'b1);
      bus.Flag_Clr = 1'b0;
      chk("flags_clr_zero", 36'(bus.Flags), 36'h1);
      drive_cycle(1'b0, 1'b0, 32'h0, 1'b1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
